// File: rtl/blk_5808e6_pkg.sv
// ============================================================================
// Module  : blk_5808e6_pkg
// Brief   : Shared payload layout, source ready latency and framing states
//           for the MAC TX timing adapter / frame encoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package blk_5808e6_pkg;

   localparam int PAYLOAD_W         = 70;
   localparam int DATA_W            = 64;
   localparam int EMPTY_W           = 3;
   localparam int OFF_EMPTY         = 0;
   localparam int OFF_EOP           = 3;
   localparam int OFF_SOP           = 4;
   localparam int OFF_ERR           = 5;
   localparam int OFF_DATA          = 6;
   localparam int READY_LATENCY_OUT = 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } frame_state_t;

   function automatic logic [PAYLOAD_W-1:0] pack_beat(
      input logic [DATA_W-1:0]  data,
      input logic               err,
      input logic               sop,
      input logic               eop,
      input logic [EMPTY_W-1:0] empty
   );
      return {data, err, sop, eop, empty};
   endfunction

endpackage

`default_nettype wire

// File: rtl/blk_5808e6_fifo.sv
// ============================================================================
// Module  : blk_5808e6_fifo
// Brief   : Synchronous DEPTH x WIDTH FIFO with show-ahead head and occupancy.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module blk_5808e6_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 70,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
   assign w_pop   = i_pop && (r_count != '0);
   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/blk_5808e6.sv
// ============================================================================
// Module  : blk_5808e6
// Brief   : 10G MAC TX timing adapter: ready-latency-0 sink to ready-latency-2
//           source through a small FIFO, with sticky framing violation flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module blk_5808e6
   import blk_5808e6_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_W-1:0]               in_data,
   input  logic                            in_error,
   input  logic                            in_startofpacket,
   input  logic                            in_endofpacket,
   input  logic [EMPTY_W-1:0]              in_empty,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [DATA_W-1:0]               out_data,
   output logic                            out_error,
   output logic                            out_startofpacket,
   output logic                            out_endofpacket,
   output logic [EMPTY_W-1:0]              out_empty,
   input  logic                            clr_err,
   output logic                            framing_err,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_level
);

   localparam int FILL_W   = $clog2(FIFO_DEPTH + 1);
   // out_valid register supplies the final stage of the source ready latency.
   localparam int RDY_PIPE = READY_LATENCY_OUT - 1;

   logic [PAYLOAD_W-1:0] w_in_payload;
   logic [PAYLOAD_W-1:0] w_head;
   logic [FILL_W-1:0]    w_fill;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_ready_d;
   logic [RDY_PIPE-1:0]  r_ready_pipe;
   logic                 r_out_valid;
   logic [PAYLOAD_W-1:0] r_out_payload;
   frame_state_t         r_state;
   frame_state_t         w_state_next;
   logic                 w_viol;
   logic                 r_framing_err;

   assign w_in_payload = pack_beat(in_data, in_error, in_startofpacket, in_endofpacket, in_empty);
   assign in_ready     = reset_n && (w_fill < FILL_W'(FIFO_DEPTH));
   assign w_push       = in_valid && in_ready;
   assign w_ready_d    = r_ready_pipe[RDY_PIPE-1];
   assign w_pop        = w_ready_d && (w_fill != '0);

   blk_5808e6_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PAYLOAD_W),
      .CNT_W (FILL_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_push  (w_push),
      .i_wdata (w_in_payload),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_count (w_fill)
   );

   if (RDY_PIPE == 1) begin : g_rdy_single
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) r_ready_pipe <= '0;
         else          r_ready_pipe <= out_ready;
      end
   end else begin : g_rdy_multi
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) r_ready_pipe <= '0;
         else          r_ready_pipe <= {r_ready_pipe[RDY_PIPE-2:0], out_ready};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid   <= 1'b0;
         r_out_payload <= '0;
      end else begin
         r_out_valid <= w_pop;
         if (w_pop) r_out_payload <= w_head;
      end
   end

   // A start inside a packet re-synchronises to that beat as a fresh start.
   always_comb begin
      w_state_next = r_state;
      w_viol       = 1'b0;
      if (w_push) begin
         case (r_state)
            ST_IDLE: begin
               w_viol       = !in_startofpacket;
               w_state_next = (in_startofpacket && !in_endofpacket) ? ST_PKT : ST_IDLE;
            end
            ST_PKT: begin
               w_viol       = in_startofpacket;
               w_state_next = in_endofpacket ? ST_IDLE : ST_PKT;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_framing_err <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_viol)       r_framing_err <= 1'b1;
         else if (clr_err) r_framing_err <= 1'b0;
      end
   end

   assign out_valid         = r_out_valid;
   assign out_data          = r_out_payload[OFF_DATA +: DATA_W];
   assign out_error         = r_out_payload[OFF_ERR];
   assign out_startofpacket = r_out_payload[OFF_SOP];
   assign out_endofpacket   = r_out_payload[OFF_EOP];
   assign out_empty         = r_out_payload[OFF_EMPTY +: EMPTY_W];
   assign framing_err       = r_framing_err;
   assign fill_level        = w_fill;

endmodule

`default_nettype wire

// File: tb/tb_blk_5808e6.sv
// ============================================================================
// Module  : tb_blk_5808e6
// Brief   : Self-checking bench for blk_5808e6 against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blk_5808e6;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic        in_error = 1'b0;
   logic        in_startofpacket = 1'b0;
   logic        in_endofpacket = 1'b0;
   logic [2:0]  in_empty = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_error;
   logic        out_startofpacket;
   logic        out_endofpacket;
   logic [2:0]  out_empty;
   logic        clr_err = 1'b0;
   logic        framing_err;
   logic [2:0]  fill_level;

   blk_5808e6 #(.FIFO_DEPTH(DEPTH)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .in_error          (in_error),
      .in_startofpacket  (in_startofpacket),
      .in_endofpacket    (in_endofpacket),
      .in_empty          (in_empty),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_error         (out_error),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_empty         (out_empty),
      .clr_err           (clr_err),
      .framing_err       (framing_err),
      .fill_level        (fill_level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: buffered beats, last emitted beat, sticky error, packet flag.
   logic [69:0] q[$];
   logic [69:0] exp_out   = '0;
   logic        exp_valid = 1'b0;
   logic        exp_err   = 1'b0;
   bit          in_pkt    = 1'b0;
   bit          rdy_d1    = 1'b0;
   bit          prev1     = 1'b0;
   bit          prev2     = 1'b0;
   int          n_in      = 0;
   int          n_out     = 0;

   wire [69:0] w_out = {out_data, out_error, out_startofpacket, out_endofpacket, out_empty};

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [69:0] mk(input logic [63:0] d, input logic er, input logic s,
                                      input logic e, input logic [2:0] emp);
      return {d, er, s, e, emp};
   endfunction

   task automatic model_reset();
      q.delete();
      exp_out   = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      in_pkt    = 1'b0;
      rdy_d1    = 1'b0;
      prev1     = 1'b0;
      prev2     = 1'b0;
   endtask

   // One clock cycle: entered and left at posedge+1.
   task automatic cycle(input bit v, input logic [69:0] beat, input bit ordy,
                        input bit clr, output bit acc);
      bit pop, sop, eop, viol;
      in_valid = v;
      {in_data, in_error, in_startofpacket, in_endofpacket, in_empty} = beat;
      out_ready = ordy;
      clr_err   = clr;
      #1;
      chk("in_ready", in_ready, q.size() < DEPTH);
      acc  = v && (q.size() < DEPTH);
      pop  = rdy_d1 && (q.size() > 0);
      viol = 1'b0;
      if (pop) begin
         exp_out = q.pop_front();
         n_out++;
      end
      exp_valid = pop;
      if (acc) begin
         q.push_back(beat);
         n_in++;
         sop    = beat[4];
         eop    = beat[3];
         viol   = in_pkt ? sop : !sop;
         in_pkt = sop ? !eop : (in_pkt && !eop);
      end
      exp_err = viol ? 1'b1 : (clr ? 1'b0 : exp_err);
      rdy_d1  = ordy;
      prev2   = prev1;
      prev1   = ordy;
      @(posedge clk);
      #1;
      chk("out_valid", out_valid, exp_valid);
      chk("out_payload", w_out, exp_out);
      chk("fill_level", fill_level, q.size());
      chk("framing_err", framing_err, exp_err);
      chk("valid_needs_ready_2_back", !out_valid || prev2, 1'b1);
   endtask

   task automatic idle(input int n, input bit ordy);
      bit a;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, ordy, 1'b0, a);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          a;
      int          base;
      int          k;
      logic [69:0] b;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_payload", w_out, '0);
      chk("rst_fill", fill_level, 0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_framing_err", framing_err, 1'b0);
      reset_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Continuous ready, 8-beat packet
      idle(1, 1'b1);
      base = n_out;
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, mk(64'(i), 1'b0, i == 1, i == 8, 3'd3), 1'b1, 1'b0, a);
         if (i == 2) chk("p1_first_out_latency", out_valid, 1'b1);
      end
      idle(4, 1'b1);
      chk("p1_beats_out", n_out - base, 8);
      chk("p1_no_err", framing_err, 1'b0);

      // Back-pressure: fill to DEPTH, then drain
      base = n_out;
      k = 1;
      for (int c = 0; c < 30 && k <= 10; c++) begin
         cycle(1'b1, mk(64'(16'hA000 + k), 1'b0, k == 1, k == 10, 3'd1),
               !(c >= 2 && c < 10), 1'b0, a);
         if (a) k++;
         if (c == 9) begin
            chk("p2_full_level", fill_level, DEPTH);
            chk("p2_full_in_ready", in_ready, 1'b0);
         end
      end
      chk("p2_all_sent", k, 11);
      idle(8, 1'b1);
      chk("p2_beats_out", n_out - base, 10);

      // Framing violations
      base = n_out;
      cycle(1'b1, mk(64'h11, 1'b0, 1'b0, 1'b0, 3'd0), 1'b1, 1'b0, a);
      chk("p3_no_sop_in_idle", framing_err, 1'b1);
      idle(1, 1'b1);
      clr_err = 1'b1;
      cycle(1'b0, '0, 1'b1, 1'b1, a);
      chk("p3_clear", framing_err, 1'b0);
      cycle(1'b1, mk(64'h22, 1'b0, 1'b1, 1'b0, 3'd0), 1'b1, 1'b0, a);
      chk("p3_clean_sop", framing_err, 1'b0);
      cycle(1'b1, mk(64'h33, 1'b0, 1'b1, 1'b0, 3'd0), 1'b1, 1'b0, a);
      chk("p3_sop_in_pkt", framing_err, 1'b1);
      cycle(1'b1, mk(64'h44, 1'b1, 1'b0, 1'b1, 3'd7), 1'b1, 1'b1, a);
      chk("p3_clear_again", framing_err, 1'b0);
      cycle(1'b1, mk(64'h55, 1'b0, 1'b0, 1'b1, 3'd2), 1'b1, 1'b1, a);
      chk("p3_set_beats_clear", framing_err, 1'b1);
      idle(4, 1'b1);
      chk("p3_beats_out", n_out - base, 5);

      // Randomised traffic
      base = n_in;
      for (int c = 0; c < 60000 && (n_in - base) < 10000; c++) begin
         b = mk({$urandom, $urandom}, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                3'($urandom_range(0, 7)));
         cycle(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)),
               $urandom_range(0, 15) == 0, a);
      end
      chk("p4_beats_in", n_in - base, 10000);
      idle(8, 1'b1);
      chk("p4_drained", fill_level, 0);

      // Reset mid-packet with 3 beats buffered
      cycle(1'b1, mk(64'hBEEF_0001, 1'b0, 1'b1, 1'b0, 3'd0), 1'b0, 1'b0, a);
      cycle(1'b1, mk(64'hBEEF_0002, 1'b0, 1'b0, 1'b0, 3'd0), 1'b0, 1'b0, a);
      cycle(1'b1, mk(64'hBEEF_0003, 1'b0, 1'b0, 1'b0, 3'd0), 1'b0, 1'b0, a);
      chk("p5_buffered", fill_level, 3);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      chk("p5_rst_out_valid", out_valid, 1'b0);
      chk("p5_rst_payload", w_out, '0);
      chk("p5_rst_fill", fill_level, 0);
      chk("p5_rst_in_ready", in_ready, 1'b0);
      chk("p5_rst_framing_err", framing_err, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("p5_release_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      base = n_out;
      cycle(1'b1, mk(64'hC0DE_0001, 1'b0, 1'b1, 1'b0, 3'd0), 1'b1, 1'b0, a);
      cycle(1'b1, mk(64'hC0DE_0002, 1'b0, 1'b0, 1'b1, 3'd4), 1'b1, 1'b0, a);
      idle(4, 1'b1);
      chk("p5_new_pkt_no_err", framing_err, 1'b0);
      chk("p5_new_pkt_out", n_out - base, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
